opt_sequencer: RTL
==================

OPT_SEQUENCER -- requirements
Module: opt_sequencer

Interface
REQ-001 SHALL have parameter base_num, default 8, meaning replicas time-multiplexed per node; legal values are 2..2**base_log and even.
REQ-002 SHALL have parameter exp_cycles, default 17, meaning exp_run length in cycles; legal minimum is 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled only on clk rising edge.
REQ-005 start  input  1  one-cycle launch pulse; honoured only in IDLE.
REQ-006 abort  input  1  stops the run and forces DRAIN from RUN or EXCH.
REQ-007 iter_num  input  32  number of sweeps to run; latched on start.
REQ-008 ex_interval  input  16  sweeps between exchange phases; latched on start; 0 means never exchange.
REQ-009 recip_in  input  17  temperature reciprocal; latched on start.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on DRAIN->IDLE.
REQ-012 or_rn_base_id / tw_rn_base_id  output  base_log each  random-stage replica index.
REQ-013 or_dd_base_id / tw_dd_base_id  output  base_log each  delta-distance-stage index.
REQ-014 or_rp_base_id / tw_rp_base_id  output  base_log each  replica-stage index.
REQ-015 or_ex_base_id / tw_ex_base_id  output  base_log each  exchange-stage index.
REQ-016 opt_run  output  1  high for every RUN-state cycle.
REQ-017 or_opt_en / tw_opt_en  output  1 each  per-cycle opt enables.
REQ-018 exp_init / exp_run / exp_fin  output  1 each  exponent-unit control.
REQ-019 exp_recip  output  17  latched recip_in, held stable while busy.

Function
REQ-020 SHALL implement the states IDLE, RUN, EXCH and DRAIN.
REQ-021 IDLE + start, iter_num!=0 -> RUN and latch the inputs; IDLE + start, iter_num==0 -> DRAIN directly.
REQ-022 In RUN, base counter bc SHALL count 0..base_num-1 and wrap; each wrap is one sweep and decrements the remaining-sweep count rem (32-bit).
REQ-023 or_rn_base_id SHALL equal bc.
REQ-024 tw_rn_base_id SHALL equal (bc + base_num/2) mod base_num.
REQ-025 The dd, rp and ex ids SHALL be the rn id of the same side delayed 1, 2 and 3 cycles, via a registered pipeline.
REQ-026 or_opt_en and tw_opt_en SHALL both equal opt_run.
REQ-027 A sweep-interval counter SHALL count completed sweeps.
REQ-028 When ex_interval!=0 and the interval counter reaches ex_interval at a wrap with rem>1: RUN -> EXCH, interval counter cleared, bc held at 0.
REQ-029 At a wrap with rem==1: RUN -> DRAIN, and rem reaches 0.
REQ-030 If the exchange condition and the last-sweep condition coincide, last-sweep SHALL win (no EXCH).
REQ-031 EXCH sequence: exp_init high 1 cycle, then exp_run high exp_cycles cycles, then exp_fin high 1 cycle, then -> RUN with bc=0.
REQ-032 exp_init, exp_run and exp_fin SHALL never overlap.
REQ-033 DRAIN SHALL last exactly 3 cycles, flushing the id pipeline, then -> IDLE with done high on the exit cycle.
REQ-034 abort in RUN or EXCH -> DRAIN next cycle; opt_run and exp_* go low immediately; done still pulses.
REQ-035 abort in IDLE or DRAIN SHALL be ignored; abort SHALL have priority over every other transition.
REQ-036 start while busy SHALL be ignored.

Reset
REQ-037 On reset==0, the state SHALL be IDLE and all counters, id outputs and pipeline stages 0.
REQ-038 On reset==0, busy, done, opt_run, or/tw_opt_en, exp_init, exp_run, exp_fin SHALL be 0 and exp_recip 0.
REQ-039 Reset mid-run SHALL abandon the run with no done pulse.

Verification
REQ-040 base_num=8, start iter_num=2, ex_interval=0 -> opt_run high 16 cycles; or_rn 0..7,0..7; tw_rn 4..7,0..3 twice; or_ex equals or_rn delayed 3 cycles; done 3 cycles after opt_run falls.
REQ-041 iter_num=3, ex_interval=1, exp_cycles=17 -> two EXCH phases of 19 cycles each (init 1, run 17, fin 1); opt_run low throughout EXCH; the third sweep ends in DRAIN, not EXCH.
REQ-042 iter_num=1, ex_interval=1 -> no EXCH (last-sweep priority); done after 8+3 cycles.
REQ-043 abort asserted on exp_run cycle 5 -> exp_run low next cycle; DRAIN for 3 cycles; done pulse; busy low afterwards.
REQ-044 start with iter_num=0 -> opt_run never high; done 3 cycles later; start pulse during busy has no effect.
REQ-045 reset driven low mid-RUN -> next cycle all outputs 0, state IDLE, no done; a subsequent start runs normally.

Source files
------------

// File: rtl/opt_sequencer.sv
// Replica-exchange optimisation sequencer: sweeps base_num replicas per node,
// interleaves exponent-unit exchange phases and drains the id pipeline at the end.
module opt_sequencer #(
  parameter int base_num   = 8,
  parameter int exp_cycles = 17,
  parameter int base_log   = $clog2(base_num)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         iter_num,
  input  logic [15:0]         ex_interval,
  input  logic [16:0]         recip_in,
  output logic                busy,
  output logic                done,
  output logic [base_log-1:0] or_rn_base_id,
  output logic [base_log-1:0] tw_rn_base_id,
  output logic [base_log-1:0] or_dd_base_id,
  output logic [base_log-1:0] tw_dd_base_id,
  output logic [base_log-1:0] or_rp_base_id,
  output logic [base_log-1:0] tw_rp_base_id,
  output logic [base_log-1:0] or_ex_base_id,
  output logic [base_log-1:0] tw_ex_base_id,
  output logic                opt_run,
  output logic                or_opt_en,
  output logic                tw_opt_en,
  output logic                exp_init,
  output logic                exp_run,
  output logic                exp_fin,
  output logic [16:0]         exp_recip,
  output logic [1:0]          dbg_state
);

  // Launch protocol: start is a one-cycle pulse accepted only while busy is low;
  // completion is reported by a one-cycle done pulse in the first idle cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXCH = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [base_log-1:0] bc_max  = base_log'(base_num - 1);
  localparam logic [base_log:0]   half_w  = (base_log + 1)'(base_num / 2);
  localparam logic [base_log:0]   num_w   = (base_log + 1)'(base_num);
  localparam logic [31:0]         fin_at  = 32'(exp_cycles + 1);

  state_t              state, state_nx;
  logic [base_log-1:0] bc;
  logic [31:0]         rem;
  logic [15:0]         ic;
  logic [15:0]         ex_int;
  logic [31:0]         ecnt;
  logic [1:0]          dcnt;
  logic [base_log:0]   tw_sum;
  logic [base_log:0]   tw_mod;
  logic                wrap, last_sweep, exch_go, exch_end, drain_end;

  assign wrap       = (state == RUN) && (bc == bc_max);
  assign last_sweep = wrap && (rem == 32'd1);
  assign exch_go    = wrap && !last_sweep && (ex_int != 16'd0) && (16'(ic + 16'd1) == ex_int);
  assign exch_end   = (state == EXCH) && (ecnt == fin_at);
  assign drain_end  = (state == DRAIN) && (dcnt == 2'd2);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Abort outranks sweep completion and exchange entry.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (iter_num != 32'd0) ? RUN : DRAIN;
      RUN: begin
        if (abort)           state_nx = DRAIN;
        else if (last_sweep) state_nx = DRAIN;
        else if (exch_go)    state_nx = EXCH;
      end
      EXCH: begin
        if (abort)         state_nx = DRAIN;
        else if (exch_end) state_nx = RUN;
      end
      DRAIN: if (drain_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bc        <= '0;
      rem       <= '0;
      ic        <= '0;
      ex_int    <= '0;
      ecnt      <= '0;
      dcnt      <= '0;
      done      <= 1'b0;
      exp_recip <= '0;
    end else begin
      done <= drain_end;
      case (state)
        IDLE: begin
          bc   <= '0;
          ecnt <= '0;
          dcnt <= '0;
          if (start) begin
            rem       <= iter_num;
            ex_int    <= ex_interval;
            exp_recip <= recip_in;
            ic        <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            bc <= '0;
          end else if (wrap) begin
            bc  <= '0;
            rem <= rem - 32'd1;
            ic  <= exch_go ? 16'd0 : 16'(ic + 16'd1);
          end else begin
            bc <= bc + 1'b1;
          end
        end
        EXCH: begin
          bc   <= '0;
          ecnt <= (abort || exch_end) ? 32'd0 : ecnt + 32'd1;
        end
        DRAIN: begin
          bc   <= '0;
          dcnt <= drain_end ? 2'd0 : dcnt + 2'd1;
        end
        default: bc <= '0;
      endcase
    end
  end

  assign tw_sum        = {1'b0, bc} + half_w;
  assign tw_mod        = (tw_sum >= num_w) ? tw_sum - num_w : tw_sum;
  assign or_rn_base_id = bc;
  assign tw_rn_base_id = opt_run ? tw_mod[base_log-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      or_dd_base_id <= '0;
      tw_dd_base_id <= '0;
      or_rp_base_id <= '0;
      tw_rp_base_id <= '0;
      or_ex_base_id <= '0;
      tw_ex_base_id <= '0;
    end else begin
      or_dd_base_id <= or_rn_base_id;
      tw_dd_base_id <= tw_rn_base_id;
      or_rp_base_id <= or_dd_base_id;
      tw_rp_base_id <= tw_dd_base_id;
      or_ex_base_id <= or_rp_base_id;
      tw_ex_base_id <= tw_rp_base_id;
    end
  end

  assign busy      = (state != IDLE);
  assign opt_run   = (state == RUN);
  assign or_opt_en = opt_run;
  assign tw_opt_en = opt_run;
  assign exp_init  = (state == EXCH) && (ecnt == 32'd0);
  assign exp_fin   = exch_end;
  assign exp_run   = (state == EXCH) && (ecnt != 32'd0) && (ecnt != fin_at);
  assign dbg_state = state;

endmodule
